multicycle_control: RTL
=======================

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 SHALL: clk  in  1  sole clock, rising-edge.
REQ-002 SHALL: rst  in  1  asynchronous, active-high reset.
REQ-003 SHALL: instr  in  32  current instruction word (IR output; valid from DECODE onward).
REQ-004 SHALL: imem_req  out  1  instruction fetch request; imem_ready  in  1  fetch done this cycle.
REQ-005 SHALL: dmem_req  out  1  data access request; dmem_we  out  1  store when 1; dmem_ready  in  1  access done this cycle.
REQ-006 SHALL: branch_cond  in  1  ALU compare result for current branch.
REQ-007 SHALL: ir_we, pc_we, rf_we  out  1 each  load IR / update PC / write register file.
REQ-008 SHALL: pc_sel  out  2  next-PC source: 0=PC+4, 1=PC+imm, 2=(rs1+imm)&~1.
REQ-009 SHALL: ExtOp  out  3  immediate format select: I=000, U=001, S=010, B=011, J=100.
REQ-010 SHALL: illegal  out  1  sticky illegal-instruction flag.

Function
REQ-011 SHALL: states IDLE, FETCH, DECODE, EXEC, MEM, WB, TRAP; state register only sequential element besides class/ExtOp registers.
REQ-012 SHALL: IDLE -> FETCH unconditionally after one cycle; no requests in IDLE.
REQ-013 SHALL: FETCH holds imem_req=1 until imem_ready; on imem_ready, ir_we=1 (same cycle), -> DECODE.
REQ-014 SHALL: DECODE classifies opcode instr[6:0]: LUI 0110111/AUIPC 0010111 (U), JAL 1101111 (J), JALR 1100111 (I), BRANCH 1100011 (B), LOAD 0000011 (I), STORE 0100011 (S), OP-IMM 0010011 (I), OP 0110011 (ExtOp 000); any other opcode -> TRAP.
REQ-015 SHALL: ExtOp and class registered at DECODE exit, stable from EXEC until next FETCH; ExtOp=000 elsewhere.
REQ-016 SHALL: EXEC: BRANCH -> pc_we=1, pc_sel=branch_cond?1:0, -> FETCH; LOAD/STORE -> MEM; others -> WB.
REQ-017 SHALL: MEM holds dmem_req=1 (dmem_we=1 for STORE) until dmem_ready; STORE on ready: pc_we=1, pc_sel=0, -> FETCH; LOAD on ready -> WB.
REQ-018 SHALL: WB: rf_we=1, pc_we=1 for exactly one cycle; pc_sel=1 for JAL, 2 for JALR, else 0; -> FETCH.
REQ-019 SHALL: TRAP: illegal=1, all request/enable outputs 0, remains until rst.
REQ-020 SHALL: zero-wait latency (FETCH to next FETCH): BRANCH 3, ALU/LUI/AUIPC/JAL/JALR/STORE 4, LOAD 5 cycles; each ready wait cycle adds one.
REQ-021 SHALL: ir_we, pc_we, rf_we each at most one pulse per instruction; never simultaneous with dmem_req deassertion glitch (Mealy terms depend only on state and ready/branch_cond).
REQ-022 SHALL: ready inputs ignored outside their own state.

Reset
REQ-023 SHALL: rst forces state IDLE, ExtOp=000, illegal=0, all other outputs 0 immediately (asynchronously), including mid-FETCH/MEM.
REQ-024 SHALL: first imem_req appears the second rising edge after rst deassertion.

Structure
REQ-025 SHALL: shared package cpu_pkg holds state enum, opcode constants, ExtOp constants, pc_sel encodings.
REQ-026 SHALL: one combinational sub-module instr_class_decoder (instr[6:0] -> class, ExtOp, legal).

Verification
REQ-027 SHALL: addi x1,x0,5 (0x00500093), imem_ready immediate -> ExtOp=000, rf_we+pc_we (pc_sel=0) in cycle 4 after FETCH entry.
REQ-028 SHALL: lw x2,4(x1) (0x0040A103), dmem_ready delayed 2 cycles -> dmem_req high 3 cycles, dmem_we=0, ExtOp=000, rf_we one cycle after ready.
REQ-029 SHALL: beq x1,x2,8 (0x00208463), branch_cond=1 -> ExtOp=011, pc_we with pc_sel=1 in EXEC, rf_we never 1; branch_cond=0 -> pc_sel=0.
REQ-030 SHALL: jal x1,8 (0x008000EF) -> ExtOp=100, WB: rf_we=1, pc_we=1, pc_sel=1.
REQ-031 SHALL: 0x00000000 -> TRAP, illegal=1, no further imem_req/pc_we until rst.
REQ-032 SHALL: rst asserted in MEM with dmem_req=1 -> dmem_req=0 same cycle, illegal=0, IDLE then FETCH after release.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared types and encodings for the multicycle controller and its decoder.
package cpu_pkg;

  // Controller sequencing states.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_TRAP   = 3'd6
  } state_t;

  // Instruction classes, grouped by the path they take through EXEC/MEM/WB.
  typedef enum logic [2:0] {
    CLS_ALU    = 3'd0,
    CLS_UPPER  = 3'd1,
    CLS_JAL    = 3'd2,
    CLS_JALR   = 3'd3,
    CLS_BRANCH = 3'd4,
    CLS_LOAD   = 3'd5,
    CLS_STORE  = 3'd6
  } instr_class_t;

  // Opcodes (instr[6:0]).
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  // Immediate format select.
  localparam logic [2:0] EXT_I = 3'b000;
  localparam logic [2:0] EXT_U = 3'b001;
  localparam logic [2:0] EXT_S = 3'b010;
  localparam logic [2:0] EXT_B = 3'b011;
  localparam logic [2:0] EXT_J = 3'b100;

  // Next-PC source.
  localparam logic [1:0] PC_SEL_PLUS4 = 2'd0;
  localparam logic [1:0] PC_SEL_REL   = 2'd1;
  localparam logic [1:0] PC_SEL_JALR  = 2'd2;

  function automatic logic is_mem_class(input instr_class_t c);
    return (c == CLS_LOAD) || (c == CLS_STORE);
  endfunction

endpackage

// File: rtl/instr_class_decoder.sv
// Purely combinational opcode classifier: class, immediate format, legality.
module instr_class_decoder
  import cpu_pkg::*;
(
  input  logic [6:0]   opcode,
  output instr_class_t cls,
  output logic [2:0]   ext_op,
  output logic         legal
);

  // Map opcode to class and immediate format; unknown opcodes are flagged illegal.
  always_comb begin
    cls    = CLS_ALU;
    ext_op = EXT_I;
    legal  = 1'b1;
    case (opcode)
      OPC_LUI,
      OPC_AUIPC: begin
        cls    = CLS_UPPER;
        ext_op = EXT_U;
      end
      OPC_JAL: begin
        cls    = CLS_JAL;
        ext_op = EXT_J;
      end
      OPC_JALR: begin
        cls    = CLS_JALR;
        ext_op = EXT_I;
      end
      OPC_BRANCH: begin
        cls    = CLS_BRANCH;
        ext_op = EXT_B;
      end
      OPC_LOAD: begin
        cls    = CLS_LOAD;
        ext_op = EXT_I;
      end
      OPC_STORE: begin
        cls    = CLS_STORE;
        ext_op = EXT_S;
      end
      OPC_OP_IMM,
      OPC_OP: begin
        cls    = CLS_ALU;
        ext_op = EXT_I;
      end
      default: begin
        legal = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle CPU control FSM: sequences fetch, decode, execute, memory and
// write-back, and parks in TRAP on an unknown opcode until reset.
//
// state  | meaning
// -------+----------------------------------------------------------
// IDLE   | one quiet cycle after reset, no requests
// FETCH  | imem_req held until imem_ready; IR loaded on ready
// DECODE | opcode classified; class/ExtOp captured on exit
// EXEC   | branches resolve PC here; others pick MEM or WB
// MEM    | dmem_req held until dmem_ready; stores retire on ready
// WB     | one-cycle register write and PC update
// TRAP   | illegal opcode seen; everything idle, illegal=1 until rst
module multicycle_control
  import cpu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr,
  output logic        imem_req,
  input  logic        imem_ready,
  output logic        dmem_req,
  output logic        dmem_we,
  input  logic        dmem_ready,
  input  logic        branch_cond,
  output logic        ir_we,
  output logic        pc_we,
  output logic        rf_we,
  output logic [1:0]  pc_sel,
  output logic [2:0]  ExtOp,
  output logic        illegal
);

  state_t       state;
  state_t       state_nxt;
  instr_class_t cls_q;
  instr_class_t dec_cls;
  logic [2:0]   ext_q;
  logic [2:0]   dec_ext;
  logic         dec_legal;

  // Only the opcode field steers control; the rest of the word feeds the datapath.
  logic unused_instr_bits;
  assign unused_instr_bits = ^instr[31:7];

  instr_class_decoder u_decoder (
    .opcode (instr[6:0]),
    .cls    (dec_cls),
    .ext_op (dec_ext),
    .legal  (dec_legal)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Capture class and immediate format as DECODE exits so they hold through WB.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cls_q <= CLS_ALU;
      ext_q <= EXT_I;
    end else if (state == ST_DECODE) begin
      cls_q <= dec_cls;
      ext_q <= dec_ext;
    end
  end

  // Next-state and outputs; Mealy terms use only state, ready and branch_cond.
  always_comb begin
    state_nxt = state;
    imem_req  = 1'b0;
    dmem_req  = 1'b0;
    dmem_we   = 1'b0;
    ir_we     = 1'b0;
    pc_we     = 1'b0;
    rf_we     = 1'b0;
    pc_sel    = PC_SEL_PLUS4;
    ExtOp     = EXT_I;
    illegal   = 1'b0;
    case (state)
      ST_IDLE: begin
        state_nxt = ST_FETCH;
      end
      ST_FETCH: begin
        imem_req = 1'b1;
        if (imem_ready) begin
          ir_we     = 1'b1;
          state_nxt = ST_DECODE;
        end
      end
      ST_DECODE: begin
        state_nxt = dec_legal ? ST_EXEC : ST_TRAP;
      end
      ST_EXEC: begin
        ExtOp = ext_q;
        if (cls_q == CLS_BRANCH) begin
          pc_we     = 1'b1;
          pc_sel    = branch_cond ? PC_SEL_REL : PC_SEL_PLUS4;
          state_nxt = ST_FETCH;
        end else if (is_mem_class(cls_q)) begin
          state_nxt = ST_MEM;
        end else begin
          state_nxt = ST_WB;
        end
      end
      ST_MEM: begin
        ExtOp    = ext_q;
        dmem_req = 1'b1;
        dmem_we  = (cls_q == CLS_STORE);
        if (dmem_ready) begin
          if (cls_q == CLS_STORE) begin
            pc_we     = 1'b1;
            pc_sel    = PC_SEL_PLUS4;
            state_nxt = ST_FETCH;
          end else begin
            state_nxt = ST_WB;
          end
        end
      end
      ST_WB: begin
        ExtOp     = ext_q;
        rf_we     = 1'b1;
        pc_we     = 1'b1;
        state_nxt = ST_FETCH;
        if (cls_q == CLS_JAL) begin
          pc_sel = PC_SEL_REL;
        end else if (cls_q == CLS_JALR) begin
          pc_sel = PC_SEL_JALR;
        end
      end
      ST_TRAP: begin
        illegal   = 1'b1;
        state_nxt = ST_TRAP;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

endmodule
